// File: rtl/mem_seq_pkg.sv
// Shared types and default widths for the memory request sequencer.
package mem_seq_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count; head is read combinationally.
module sync_fifo #(
  parameter type         elem_t = logic [7:0],
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  elem_t                    push_data,
  input  logic                     pop,
  output elem_t                    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Queues client read/write requests and drives the single-port memory pins one op at a time,
// returning read data over a valid/ready response channel.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read_write,
  output logic              mem_chip_en,
  output logic              busy
);

  state_t                 state;
  mem_op_t                fifo_in;
  mem_op_t                fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_in   = '{write: req_write,
                       addr:  MEM_ADDR_W'(req_addr),
                       wdata: MEM_DATA_W'(req_wdata)};

  // Pop from IDLE, or chain straight into the next op after a write issue.
  assign fifo_pop  = !fifo_empty &&
                     ((state == IDLE) || ((state == ISSUE) && mem_read_write));
  assign busy      = (fifo_count != '0) || (state != IDLE);

  sync_fifo #(
    .elem_t (mem_op_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      mem_address    <= '0;
      mem_data_in    <= '0;
      mem_read_write <= 1'b0;
      mem_chip_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) state <= ISSUE;
        end
        ISSUE: begin
          if (mem_read_write) begin
            if (!fifo_pop) begin
              mem_chip_en <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            rsp_rdata   <= mem_data_out;
            rsp_valid   <= 1'b1;
            mem_chip_en <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Load the memory pins from the popped op; reads keep the previous data_in.
      if (fifo_pop) begin
        mem_address    <= ADDR_W'(fifo_head.addr);
        mem_read_write <= fifo_head.write;
        mem_chip_en    <= 1'b1;
        if (fifo_head.write) mem_data_in <= DATA_W'(fifo_head.wdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural 256x8 memory and in-order scoreboards.
module tb_mem_req_sequencer;
  import mem_seq_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_read_write;
  logic          mem_chip_en;
  logic          busy;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_op_t;

  exp_op_t       op_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] phys [256];
  logic [DW-1:0] refm [256];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  mem_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write),
    .mem_chip_en    (mem_chip_en),
    .busy           (busy)
  );

  // Behavioural memory: asynchronous read, write on the edge ending a chip_en cycle.
  assign mem_data_out = phys[mem_address];
  always @(posedge clk) begin
    if (mem_chip_en && mem_read_write) phys[mem_address] <= mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: ops queued on acceptance, compared at issue; read data predicted at issue.
  always @(negedge clk) begin
    if (mem_chip_en) begin
      chk("op_expected", 32'(op_q.size() != 0), 32'(1));
      if (op_q.size() != 0) begin
        automatic exp_op_t e = op_q.pop_front();
        chk("op_rw", 32'(mem_read_write), 32'(e.w));
        chk("op_addr", 32'(mem_address), 32'(e.a));
        if (e.w) begin
          chk("op_wdata", 32'(mem_data_in), 32'(e.d));
          refm[e.a] <= e.d;
        end else begin
          rsp_q.push_back(refm[e.a]);
        end
      end
    end
    if (rsp_valid && !rst) begin
      chk("rsp_expected", 32'(rsp_q.size() != 0), 32'(1));
      if (rsp_ready && rsp_q.size() != 0)
        chk("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
    end
    if (!rst && req_valid && req_ready)
      op_q.push_back(exp_op_t'{w: req_write, a: req_addr, d: req_wdata});
    if (rst) begin
      op_q.delete();
      rsp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 100), 32'(1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
    chk({tag, "_mem_address"}, 32'(mem_address), 32'(0));
    chk({tag, "_mem_data_in"}, 32'(mem_data_in), 32'(0));
    chk({tag, "_mem_rw"}, 32'(mem_read_write), 32'(0));
    chk({tag, "_chip_en"}, 32'(mem_chip_en), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      phys[i] = 8'(i ^ 8'h5A);
      refm[i] = 8'(i ^ 8'h5A);
    end
    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b0;

    // Single write then read of address 0x10.
    send(1'b1, 8'h10, 8'h3C);
    chk("wr_chip_lat0", 32'(mem_chip_en), 32'(0));
    tick();
    chk("wr_chip", 32'(mem_chip_en), 32'(1));
    chk("wr_rw", 32'(mem_read_write), 32'(1));
    chk("wr_addr", 32'(mem_address), 32'(8'h10));
    chk("wr_data", 32'(mem_data_in), 32'(8'h3C));
    tick();
    chk("wr_chip_off", 32'(mem_chip_en), 32'(0));
    chk("wr_busy_off", 32'(busy), 32'(0));
    send(1'b0, 8'h10, 8'h00);
    chk("rd_rsp_lat0", 32'(rsp_valid), 32'(0));
    tick();
    chk("rd_chip", 32'(mem_chip_en), 32'(1));
    chk("rd_rw", 32'(mem_read_write), 32'(0));
    chk("rd_data_in_held", 32'(mem_data_in), 32'(8'h3C));
    chk("rd_rsp_lat1", 32'(rsp_valid), 32'(0));
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'(8'h3C));
    chk("rd_chip_off", 32'(mem_chip_en), 32'(0));
    tick();
    chk("rd_rsp_cleared", 32'(rsp_valid), 32'(0));

    // Burst fill behind a stalled read response.
    rsp_ready = 1'b0;
    send(1'b0, 8'h10, 8'h00);
    for (int i = 0; i < DEPTH; i++) send(1'b1, 8'(8'h20 + i), 8'(8'hA0 + i));
    chk("fill_ready_low", 32'(req_ready), 32'(0));
    chk("fill_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("fill_rsp_rdata", 32'(rsp_rdata), 32'(8'h3C));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fill_no_issue", 32'(mem_chip_en), 32'(0));
      chk("fill_ready_held", 32'(req_ready), 32'(0));
    end

    // New request at full while the FSM starts popping.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h24;
    req_wdata = 8'hA4;
    rsp_ready = 1'b1;
    tick();
    chk("full_ready_after_hs", 32'(req_ready), 32'(0));
    chk("full_rsp_cleared", 32'(rsp_valid), 32'(0));
    tick();
    chk("full_ready_after_pop", 32'(req_ready), 32'(1));
    chk("full_chip", 32'(mem_chip_en), 32'(1));
    chk("full_addr0", 32'(mem_address), 32'(8'h20));
    tick();
    req_valid = 1'b0;
    chk("full_addr1", 32'(mem_address), 32'(8'h21));
    wait_idle();
    chk("fill_ops_drained", 32'(op_q.size()), 32'(0));

    // Back-to-back write stream to 0xFC..0xFF.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'hFC + i), 8'(8'hC0 + i));
      if (i > 0) begin
        chk("ws_chip", 32'(mem_chip_en), 32'(1));
        chk("ws_addr", 32'(mem_address), 32'(8'(8'hFC + i - 1)));
      end
    end
    tick();
    chk("ws_chip_last", 32'(mem_chip_en), 32'(1));
    chk("ws_addr_last", 32'(mem_address), 32'(8'hFF));
    chk("ws_data_last", 32'(mem_data_in), 32'(8'hC3));
    tick();
    chk("ws_chip_off", 32'(mem_chip_en), 32'(0));
    chk("ws_busy_off", 32'(busy), 32'(0));

    // Response backpressure with a write queued behind the read.
    rsp_ready = 1'b0;
    send(1'b0, 8'h00, 8'h00);
    send(1'b1, 8'h30, 8'h5E);
    chk("bp_chip", 32'(mem_chip_en), 32'(1));
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("bp_rsp_rdata", 32'(rsp_rdata), 32'(8'h5A));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_rdata", 32'(rsp_rdata), 32'(8'h5A));
      chk("bp_no_issue", 32'(mem_chip_en), 32'(0));
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_no_issue", 32'(mem_chip_en), 32'(0));
    tick();
    chk("bp_wr_chip", 32'(mem_chip_en), 32'(1));
    chk("bp_wr_addr", 32'(mem_address), 32'(8'h30));
    wait_idle();

    // Reset during the ISSUE of a read with two writes queued.
    rsp_ready = 1'b0;
    send(1'b0, 8'h01, 8'h00);
    send(1'b0, 8'h10, 8'h00);
    send(1'b1, 8'h40, 8'h11);
    send(1'b1, 8'h41, 8'h22);
    chk("rst_pre_rsp", 32'(rsp_rdata), 32'(8'h5B));
    rsp_ready = 1'b1;
    tick();
    chk("rst_pre_hs", 32'(rsp_valid), 32'(0));
    tick();
    chk("rst_pre_issue", 32'(mem_chip_en), 32'(1));
    chk("rst_pre_rw", 32'(mem_read_write), 32'(0));
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
      chk("post_rst_no_issue", 32'(mem_chip_en), 32'(0));
    end
    send(1'b1, 8'h50, 8'h77);
    send(1'b0, 8'h50, 8'h00);
    tick();
    tick();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("post_rst_rsp_rdata", 32'(rsp_rdata), 32'(8'h77));
    wait_idle();
    tick();
    chk("end_ops_empty", 32'(op_q.size()), 32'(0));
    chk("end_rsp_empty", 32'(rsp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_sequencer.md
# mem_req_sequencer

Request front-end for the 256×8 single-port memory. Accepts read/write requests from a client over a valid/ready handshake, buffers them in a small in-order FIFO, and drives the memory's address, data, read_write and chip_en pins one operation at a time. Captures read data and returns it over a second valid/ready channel, so clients never have to touch memory pin timing.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 entries)
- DATA_W, 8, memory data width
- DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports (the clock is `clk`; the reset is `rst`, synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  client request present
- req_ready  out  1  FIFO can accept (= !full)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  client takes read data
- rsp_rdata  out  DATA_W  read data
- mem_address  out  ADDR_W  to memory address
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out
- mem_read_write  out  1  1 = write, 0 = read
- mem_chip_en  out  1  memory enable, one-cycle pulse per operation
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- A request is accepted on a cycle with req_valid && req_ready; {write, addr, wdata} is pushed to the FIFO.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop its head into the op register, load the mem_* output registers from it, set mem_chip_en=1, and go to ISSUE.
  - ISSUE (exactly one cycle, chip_en high):
    - Write: deassert chip_en. If the FIFO is non-empty, pop the next op, reload mem_* and stay in ISSUE; otherwise return to IDLE.
    - Read: sample mem_data_out into rsp_rdata, set rsp_valid=1, deassert chip_en, go to RESP.
  - RESP: hold rsp_valid and rsp_rdata stable until rsp_ready. On the handshake, clear rsp_valid and move to IDLE; no issue happens in this cycle.
- Ordering is strictly in order, with at most one outstanding read. A pending response blocks all later ops, writes included.
- mem_address, mem_data_in and mem_read_write hold their last values while chip_en is low. For reads, mem_data_in holds its previous value.
- Push and pop in the same cycle are both allowed and leave the occupancy unchanged.
- A push into a full FIFO cannot happen, because req_ready is 0. Client req_valid while req_ready=0 is ignored; the client must hold its request.
- Address and data pass through unmodified, with no arithmetic. FIFO pointers are log2(DEPTH) bits and wrap naturally; a separate count is log2(DEPTH)+1 bits.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_address=0, mem_data_in=0, mem_read_write=0, mem_chip_en=0, busy=0, FIFO empty, state IDLE.
- rst asserted in any state, including mid-ISSUE or RESP, takes effect at the next edge. It discards FIFO contents and any pending response, and drops chip_en that same edge.
- Latency with the FIFO empty and the FSM idle:
  - Accept at edge N; chip_en is high during cycle N+1 to N+2.
  - A read response is valid from edge N+2.
- Back-to-back writes produce one chip_en pulse per cycle, with chip_en staying continuously high.
- A read costs at least 3 cycles of throughput: ISSUE, then RESP, then IDLE.
- req_ready depends only on registered FIFO state, with no combinational path from rsp_ready or req_valid.

## Structure
- Package mem_seq_pkg holds:
  - the state enum (IDLE, ISSUE, RESP)
  - a packed struct mem_op_t {write, addr, wdata}
  - default width constants
- Sub-module sync_fifo is parameterized on element type/width and DEPTH, with push/pop/full/empty/count. It is the single natural split; the FSM and output registers stay in mem_req_sequencer.

## Test plan
- Single write then read: write 0x3C→addr 0x10, then read 0x10. Exactly one chip_en pulse per op, with read_write 1 then 0. rsp_rdata=0x3C and rsp_valid rises 2 cycles after the read is accepted.
- Burst fill: hold rsp_ready=0 and push a read followed by DEPTH writes. req_ready falls after the FIFO holds DEPTH entries and no writes are issued while rsp_valid is high. Releasing rsp_ready drains everything in order.
- Write stream: 4 writes on consecutive cycles to addrs 0xFC–0xFF. chip_en stays high for 4 consecutive cycles with the matching addr/data each cycle, and busy falls the cycle after.
- Backpressure: read addr 0x00 with rsp_ready low for 5 cycles. rsp_valid and rsp_rdata stay stable and no further chip_en pulses occur until the handshake.
- Reset mid-operation: assert rst during ISSUE of a read with 2 ops queued. On the next edge all outputs equal their reset values, no response is ever produced, and a fresh request afterwards works normally.
- Simultaneous push/pop at full: with DEPTH entries held and the FSM popping, present a new request. It is not accepted that cycle and is accepted the cycle after; count never exceeds DEPTH.
